// File: rtl/if_id_skid_stage.sv
// if_id_skid_stage: two-entry (main + skid) pipeline stage between fetch and
// decode. Valid/ready handshakes on both sides, synchronous flush, NOP bubble
// on the output when empty, and saturating stall/flush event counters.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           squash every held beat (branch/jump redirect)
//   in_valid/ready  upstream handshake; in_ready depends only on state and reset
//   in_pc/in_instr  incoming beat payload
//   out_valid/ready downstream handshake, driven from the main entry
//   out_pc/instr    main entry payload; 0 / NOP_INSTR while out_valid=0
//   stall_cnt       cycles with out_valid && !out_ready (saturating)
//   flush_cnt       flush cycles that discarded at least one valid beat
module if_id_skid_stage #(
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INSTR_W = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
);

   logic               main_valid, main_valid_n;
   logic [PC_W-1:0]    main_pc, main_pc_n;
   logic [INSTR_W-1:0] main_instr, main_instr_n;
   logic               skid_valid, skid_valid_n;
   logic [PC_W-1:0]    skid_pc, skid_pc_n;
   logic [INSTR_W-1:0] skid_instr, skid_instr_n;
   logic [CNT_W-1:0]   stall_cnt_n, flush_cnt_n;
   logic               acc, pop;

   // Back-pressure is decoded from the skid register only, never from out_ready.
   assign in_ready = !skid_valid && !reset;
   assign acc      = in_valid && in_ready;
   assign pop      = main_valid && out_ready;

   // Output view of the main entry, with a bubble when it is empty.
   assign out_valid = main_valid;
   assign out_pc    = main_valid ? main_pc : '0;
   assign out_instr = main_valid ? main_instr : NOP_INSTR;

   // Next-state for both entries and both counters.
   always_comb begin
      main_valid_n = main_valid;
      main_pc_n    = main_pc;
      main_instr_n = main_instr;
      skid_valid_n = skid_valid;
      skid_pc_n    = skid_pc;
      skid_instr_n = skid_instr;
      stall_cnt_n  = stall_cnt;
      flush_cnt_n  = flush_cnt;

      if (main_valid && !out_ready && (stall_cnt != '1))
         stall_cnt_n = stall_cnt + CNT_W'(1);

      if (flush) begin
         main_valid_n = 1'b0;
         skid_valid_n = 1'b0;
         if ((main_valid || skid_valid) && (flush_cnt != '1))
            flush_cnt_n = flush_cnt + CNT_W'(1);
      end else if (skid_valid) begin
         // Full: skid drains into main before anything newer can enter.
         if (pop) begin
            main_pc_n    = skid_pc;
            main_instr_n = skid_instr;
            skid_valid_n = 1'b0;
         end
      end else if (main_valid) begin
         if (pop && acc) begin
            main_pc_n    = in_pc;
            main_instr_n = in_instr;
         end else if (pop) begin
            main_valid_n = 1'b0;
         end else if (acc) begin
            skid_valid_n = 1'b1;
            skid_pc_n    = in_pc;
            skid_instr_n = in_instr;
         end
      end else if (acc) begin
         main_valid_n = 1'b1;
         main_pc_n    = in_pc;
         main_instr_n = in_instr;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         main_instr <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         main_valid <= main_valid_n;
         main_pc    <= main_pc_n;
         main_instr <= main_instr_n;
         skid_valid <= skid_valid_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
         stall_cnt  <= stall_cnt_n;
         flush_cnt  <= flush_cnt_n;
      end
   end

endmodule
